// File: rtl/microwave_ctrl.sv
// Cook-timer sequencer: keypad digit entry, start/stop/door handling, timer pin control
// and completion beep. Every output is driven from a register.
module microwave_ctrl #(
   parameter int unsigned DONE_CYCLES = 200,
   parameter int unsigned MAX_DIGITS  = 3
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_start,
   input  logic       key_stop,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic [3:0] timer_data,
   output logic       timer_loadn,
   output logic       timer_en,
   output logic       timer_clearn,
   output logic       mag_on,
   output logic       beep,
   output logic [2:0] state
);

   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
   localparam int unsigned BW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ENTRY  = 3'd1,
      COOK   = 3'd2,
      PAUSED = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t          cur_state, nxt_state;
   logic [CW-1:0]   count, nxt_count;
   logic [BW-1:0]   beep_cnt, nxt_beep_cnt;
   logic [3:0]      nxt_data;
   logic            nxt_loadn, nxt_en, nxt_clearn, nxt_mag, nxt_beep;
   logic            digit_ok, start_ok;

   assign state = cur_state;

   // start and stop both mask a digit arriving on the same edge
   assign digit_ok = key_valid && (key_digit <= 4'd9) && (count < CW'(MAX_DIGITS))
                     && !key_start && !key_stop;
   assign start_ok = key_start && door_closed && !timer_zero;

   always_comb begin
      nxt_state    = cur_state;
      nxt_count    = count;
      nxt_beep_cnt = beep_cnt;
      nxt_data     = timer_data;
      nxt_loadn    = 1'b1;
      nxt_clearn   = 1'b1;
      nxt_en       = timer_en;
      nxt_mag      = mag_on;
      nxt_beep     = beep;
      case (cur_state)
         IDLE: begin
            if (digit_ok) begin
               nxt_data  = key_digit;
               nxt_loadn = 1'b0;
               nxt_count = count + CW'(1);
               nxt_state = ENTRY;
            end
         end
         ENTRY: begin
            if (key_stop) begin
               nxt_state  = IDLE;
               nxt_clearn = 1'b0;
               nxt_count  = '0;
            end else if (start_ok) begin
               nxt_state = COOK;
               nxt_en    = 1'b1;
               nxt_mag   = 1'b1;
            end else if (digit_ok) begin
               nxt_data  = key_digit;
               nxt_loadn = 1'b0;
               nxt_count = count + CW'(1);
            end
         end
         COOK: begin
            if (timer_zero) begin
               nxt_state    = DONE;
               nxt_en       = 1'b0;
               nxt_mag      = 1'b0;
               nxt_beep     = 1'b1;
               nxt_beep_cnt = BW'(DONE_CYCLES - 1);
            end else if (!door_closed || key_stop) begin
               nxt_state = PAUSED;
               nxt_en    = 1'b0;
               nxt_mag   = 1'b0;
            end
         end
         PAUSED: begin
            if (key_stop) begin
               nxt_state  = IDLE;
               nxt_clearn = 1'b0;
               nxt_count  = '0;
            end else if (start_ok) begin
               nxt_state = COOK;
               nxt_en    = 1'b1;
               nxt_mag   = 1'b1;
            end
         end
         DONE: begin
            if (key_stop || (beep_cnt == '0)) begin
               nxt_state  = IDLE;
               nxt_beep   = 1'b0;
               nxt_clearn = 1'b0;
               nxt_count  = '0;
            end else begin
               nxt_beep_cnt = beep_cnt - BW'(1);
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         cur_state    <= IDLE;
         count        <= '0;
         beep_cnt     <= '0;
         timer_data   <= '0;
         timer_loadn  <= 1'b1;
         timer_en     <= 1'b0;
         timer_clearn <= 1'b0;
         mag_on       <= 1'b0;
         beep         <= 1'b0;
      end else begin
         cur_state    <= nxt_state;
         count        <= nxt_count;
         beep_cnt     <= nxt_beep_cnt;
         timer_data   <= nxt_data;
         timer_loadn  <= nxt_loadn;
         timer_en     <= nxt_en;
         timer_clearn <= nxt_clearn;
         mag_on       <= nxt_mag;
         beep         <= nxt_beep;
      end
   end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed scenarios followed by random key/door/zero traffic,
// all checked against a phase/queue reference model of the controller.
module tb_microwave_ctrl;

   localparam int unsigned DC = 200;
   localparam int unsigned MD = 3;

   logic       clock = 1'b0;
   logic       clearn = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic       key_start = 1'b0;
   logic       key_stop = 1'b0;
   logic       door_closed = 1'b1;
   logic       timer_zero = 1'b0;
   logic [3:0] timer_data;
   logic       timer_loadn, timer_en, timer_clearn, mag_on, beep;
   logic [2:0] state;

   microwave_ctrl #(.DONE_CYCLES(DC), .MAX_DIGITS(MD)) dut (
      .clock(clock), .clearn(clearn), .key_valid(key_valid), .key_digit(key_digit),
      .key_start(key_start), .key_stop(key_stop), .door_closed(door_closed),
      .timer_zero(timer_zero), .timer_data(timer_data), .timer_loadn(timer_loadn),
      .timer_en(timer_en), .timer_clearn(timer_clearn), .mag_on(mag_on), .beep(beep),
      .state(state)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int loads = 0;
   int beeps = 0;

   // reference model: phase 0..4 = idle/entry/cook/paused/done
   int         m_phase;
   int         m_digits[$];
   int         m_beep_left;
   logic [3:0] e_data;
   logic       e_loadn, e_en, e_clearn, e_mag, e_beep;

   task automatic model_reset();
      m_phase = 0;
      m_digits.delete();
      m_beep_left = 0;
      e_data = 4'd0; e_loadn = 1'b1; e_en = 1'b0; e_clearn = 1'b0; e_mag = 1'b0; e_beep = 1'b0;
   endtask

   task automatic model_clear();
      m_phase = 0;
      m_digits.delete();
      e_clearn = 1'b0;
   endtask

   task automatic model_step();
      bit take, go;
      take = key_valid && (int'(key_digit) <= 9) && (m_digits.size() < int'(MD))
             && !key_start && !key_stop;
      go = key_start && door_closed && !timer_zero;
      e_loadn = 1'b1;
      e_clearn = 1'b1;
      if (m_phase == 1 && key_stop) model_clear();
      else if (m_phase == 3 && key_stop) model_clear();
      else if ((m_phase == 1 || m_phase == 3) && go) begin
         m_phase = 2; e_en = 1'b1; e_mag = 1'b1;
      end else if ((m_phase == 0 || m_phase == 1) && take) begin
         m_digits.push_back(int'(key_digit));
         e_data = key_digit; e_loadn = 1'b0; m_phase = 1;
      end else if (m_phase == 2) begin
         if (timer_zero) begin
            m_phase = 4; e_en = 1'b0; e_mag = 1'b0; e_beep = 1'b1; m_beep_left = int'(DC);
         end else if (!door_closed || key_stop) begin
            m_phase = 3; e_en = 1'b0; e_mag = 1'b0;
         end
      end else if (m_phase == 4) begin
         m_beep_left--;
         if (key_stop || m_beep_left == 0) begin
            model_clear(); e_beep = 1'b0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("state",  16'(state),        16'(m_phase));
      chk("data",   16'(timer_data),   16'(e_data));
      chk("loadn",  16'(timer_loadn),  16'(e_loadn));
      chk("en",     16'(timer_en),     16'(e_en));
      chk("clearn", 16'(timer_clearn), 16'(e_clearn));
      chk("mag",    16'(mag_on),       16'(e_mag));
      chk("beep",   16'(beep),         16'(e_beep));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_outputs();
      if (timer_loadn === 1'b0) loads++;
      if (beep === 1'b1) beeps++;
   endtask

   task automatic press(input logic [3:0] d);
      key_valid = 1'b1; key_digit = d;
      tick();
      key_valid = 1'b0;
      tick();
   endtask

   task automatic start_key();
      key_start = 1'b1; tick(); key_start = 1'b0;
   endtask

   task automatic stop_key();
      key_stop = 1'b1; tick(); key_stop = 1'b0;
   endtask

   initial begin
      // reset
      model_reset();
      #12;
      check_outputs();
      clearn = 1'b1;
      tick();

      // 1: load 1,3,0 then start
      loads = 0;
      press(4'd1); press(4'd3); press(4'd0);
      chk("t1_loads", 16'(loads), 16'd3);
      chk("t1_last_data", 16'(timer_data), 16'd0);
      start_key();
      chk("t1_cook", 16'(state), 16'd2);
      chk("t1_mag", 16'(mag_on), 16'd1);
      repeat (5) tick();

      // 2: timer reaches zero, beep for DC cycles, then clear back to idle
      beeps = 0;
      timer_zero = 1'b1; tick(); timer_zero = 1'b0;
      chk("t2_done", 16'(state), 16'd4);
      for (int i = 0; i < int'(DC) + 20 && state !== 3'd0; i++) tick();
      chk("t2_idle", 16'(state), 16'd0);
      chk("t2_beep_len", 16'(beeps), 16'(DC));
      chk("t2_clearn", 16'(timer_clearn), 16'd0);
      tick();

      // 3: door open mid-cook, start ignored while open, resume after closing
      press(4'd2); start_key(); repeat (3) tick();
      door_closed = 1'b0; tick();
      chk("t3_paused", 16'(state), 16'd3);
      chk("t3_mag", 16'(mag_on), 16'd0);
      start_key();
      chk("t3_open_start", 16'(state), 16'd3);
      door_closed = 1'b1; tick();
      start_key();
      chk("t3_resume", 16'(state), 16'd2);
      stop_key();
      chk("t3_stop_pause", 16'(state), 16'd3);
      stop_key();
      chk("t3_stop_idle", 16'(state), 16'd0);
      tick();

      // 4: fourth digit and an out-of-range key are dropped
      loads = 0;
      press(4'd5); press(4'd9); press(4'd9); press(4'd7); press(4'd12);
      chk("t4_loads", 16'(loads), 16'd3);
      chk("t4_data", 16'(timer_data), 16'd9);
      stop_key(); tick();

      // 5: start+stop together, then start with timer already zero
      press(4'd4);
      key_start = 1'b1; key_stop = 1'b1; tick(); key_start = 1'b0; key_stop = 1'b0;
      chk("t5_startstop", 16'(state), 16'd0);
      chk("t5_clearn", 16'(timer_clearn), 16'd0);
      press(4'd4);
      timer_zero = 1'b1; start_key(); timer_zero = 1'b0;
      chk("t5_zero_start", 16'(state), 16'd1);
      stop_key(); tick();

      // 6: asynchronous reset mid-cook
      press(4'd1); start_key(); tick();
      chk("t6_cook", 16'(state), 16'd2);
      #2 clearn = 1'b0;
      #1 model_reset();
      check_outputs();
      @(negedge clock) clearn = 1'b1;
      tick();
      chk("t6_idle", 16'(state), 16'd0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         key_valid   = ($urandom_range(0, 3) == 0);
         key_digit   = 4'($urandom_range(0, 15));
         key_start   = ($urandom_range(0, 7) == 0);
         key_stop    = ($urandom_range(0, 40) == 0);
         timer_zero  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 19) == 0) door_closed = ~door_closed;
         tick();
      end
      key_valid = 1'b0; key_start = 1'b0; key_stop = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
